mem_req_arb: RTL and testbench
==============================

# mem_req_arb

Request-side companion of the read-data return mux: accepts read/write requests from 32 compute clients, arbitrates them onto 16 memory banks (one access per bank per cycle), and drives the bank command ports. For every granted read, the block tracks the requesting client through the bank read latency and emits, per bank, the 5-bit client index and a valid flag aligned with the returning bank data. These feed the return mux that routes bank data back to clients.

## Interface
Parameters:
- NUM_CLIENTS, 32, requesting clients; fixed at 32 because the client index is 5 bits.
- NUM_BANKS, 16, memory banks; the bank select is 4 bits.
- ADDR_W, 10, word address width inside a bank.
- DATA_W, 256, data word width.
- RD_LAT, 1, bank read latency in cycles, measured from the bank_cs cycle to data valid; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- client_req  in  [31:0]  per-client request valid, held until granted.
- client_we  in  [31:0]  1 = write, 0 = read.
- client_bank  in  [31:0][3:0]  target bank.
- client_addr  in  [31:0][ADDR_W-1:0]  address within the bank.
- client_wdata  in  [31:0][DATA_W-1:0]  write data.
- client_gnt  out  [31:0]  combinational grant; request accepted this cycle.
- bank_cs  out  [15:0]  registered bank access strobe.
- bank_we  out  [15:0]  registered write enable.
- bank_addr  out  [15:0][ADDR_W-1:0]  registered address.
- bank_wdata  out  [15:0][DATA_W-1:0]  registered write data.
- bank_rd_vld  out  [15:0]  read data from bank b is valid this cycle.
- client_to_send  out  [15:0][4:0]  client index owning bank b's read data.

## Operation
- Handshake: a request transfers in a cycle where client_req[c]=1 and client_gnt[c]=1. The client holds req, we, bank, addr and wdata stable until it is granted. After a grant the client may present a new request in the next cycle.
- Per-bank arbiter: the candidates for bank b are clients with client_req=1 and client_bank==b. Exactly one candidate is granted per bank per cycle if any exists. A client never receives more than one grant, because it targets only one bank.
- Round-robin (default): each bank has a 5-bit pointer, reset to 0. The first candidate at or after the pointer, searching upward modulo 32, wins. On a grant the pointer becomes (winner+1) mod 32, so 31 wraps to 0. With no candidates the pointer holds.
- Command register: the winner's we, addr and wdata are captured into the bank_* registers with bank_cs=1. With no winner, bank_cs=0 and the other bank_* outputs hold their last value.
- Read tracking: for each bank, a shift pipeline of depth RD_LAT carries {vld, client index}. vld is 1 only for granted reads (we=0). Writes never produce bank_rd_vld.
- Reset: all outputs go to 0, all pointers to 0, and the pipelines are cleared. In-flight reads are dropped silently, and bank_rd_vld stays 0 until new reads emerge.

## Timing
- Request in cycle T gives client_gnt in T (combinational), bank_cs/addr/we/wdata in T+1, and bank_rd_vld/client_to_send in T+1+RD_LAT.
- Throughput: 1 access per bank per cycle; 16 concurrent accesses when all clients target distinct banks.
- No combinational path from client inputs to bank_* or bank_rd_vld outputs.
- Simultaneous read and write requests to the same bank arbitrate identically; there is no read/write priority.
- Back-to-back reads to the same bank by different clients produce consecutive bank_rd_vld cycles, each with the correct index.

## Configuration
- MEM_REQ_ARB_FIXED_PRIO_EN defined: every bank uses fixed priority, where the lowest client index wins. Pointers are not implemented and starvation is possible.
- Undefined (default): round-robin as described above.

## Test plan
- Reset: assert rst_n=0 mid-stream while reads are in flight. All outputs must read 0, and no bank_rd_vld may appear for the pre-reset reads after release.
- Single read: client 7 reads bank 3 at addr 0x12 in cycle T. Required: gnt[7] in T; bank_cs[3]=1, we=0, addr=0x12 in T+1; bank_rd_vld[3]=1 with client_to_send[3]=7 in T+1+RD_LAT.
- Contention: clients 0, 5 and 31 hold reads to bank 9 continuously. Required grant order is 0, 5, 31, 0, …, each once per 3 cycles. With MEM_REQ_ARB_FIXED_PRIO_EN, client 0 is granted every cycle.
- Full parallelism: clients 0..15 read banks 0..15 in one cycle. Required: all 16 granted, bank_cs=0xFFFF, and client_to_send[b]=b with all bank_rd_vld set.
- Write: client 20 writes wdata=all-ones to bank 15, addr 0x3FF. Required: bank_we[15]=1 in T+1, and no bank_rd_vld[15] pulse.
- Pointer wrap: after granting client 31 on bank 2, clients 0 and 30 request bank 2. Required: client 0 is granted first.

Source files
------------

// File: rtl/mem_req_arb.sv
// Request arbiter: 32 clients onto 16 banks, one access per bank per cycle, with read-owner tracking.
// Build option MEM_REQ_ARB_FIXED_PRIO_EN selects lowest-index-wins fixed priority instead of round-robin.
module mem_req_arb #(
  parameter int NUM_CLIENTS = 32,
  parameter int NUM_BANKS   = 16,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 256,
  parameter int RD_LAT      = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CLIENTS-1:0]                client_req,
  input  logic [NUM_CLIENTS-1:0]                client_we,
  input  logic [NUM_CLIENTS-1:0][3:0]           client_bank,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]    client_addr,
  input  logic [NUM_CLIENTS-1:0][DATA_W-1:0]    client_wdata,
  output logic [NUM_CLIENTS-1:0]                client_gnt,
  output logic [NUM_BANKS-1:0]                  bank_cs,
  output logic [NUM_BANKS-1:0]                  bank_we,
  output logic [NUM_BANKS-1:0][ADDR_W-1:0]      bank_addr,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]      bank_wdata,
  output logic [NUM_BANKS-1:0]                  bank_rd_vld,
  output logic [NUM_BANKS-1:0][4:0]             client_to_send
);

  logic [NUM_BANKS-1:0][NUM_CLIENTS-1:0] cand_s;
  logic [NUM_BANKS-1:0]                  win_vld_s;
  logic [NUM_BANKS-1:0][4:0]             win_idx_s;
  logic [NUM_BANKS-1:0][4:0]             start_s;
  logic [NUM_BANKS-1:0][4:0]             cmd_idx_r;
  logic [RD_LAT-1:0][NUM_BANKS-1:0]      pipe_vld_r;
  logic [RD_LAT-1:0][NUM_BANKS-1:0][4:0] pipe_idx_r;

  // Sort requests into per-bank candidate vectors
  always_comb begin
    cand_s = '0;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      cand_s[client_bank[c]][c] = client_req[c];
    end
  end

  // Per-bank search: first candidate at or after the start index, modulo 32
  always_comb begin
    logic [4:0] idx_v;
    idx_v     = 5'd0;
    win_vld_s = '0;
    win_idx_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        idx_v = start_s[b] + 5'(i);
        if (!win_vld_s[b] && cand_s[b][idx_v]) begin
          win_vld_s[b] = 1'b1;
          win_idx_s[b] = idx_v;
        end else begin
          win_vld_s[b] = win_vld_s[b];
        end
      end
    end
  end

  // A client is granted when it is the winner of the bank it targets
  always_comb begin
    client_gnt = '0;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      if (win_vld_s[client_bank[c]] && (win_idx_s[client_bank[c]] == 5'(c))) begin
        client_gnt[c] = 1'b1;
      end else begin
        client_gnt[c] = 1'b0;
      end
    end
  end

`ifdef MEM_REQ_ARB_FIXED_PRIO_EN
  assign start_s = '0;
`else
  logic [NUM_BANKS-1:0][4:0] ptr_r;

  // Round-robin pointers advance past each winner; 31 wraps to 0 through 5-bit overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (win_vld_s[b]) begin
          ptr_r[b] <= win_idx_s[b] + 5'd1;
        end else begin
          ptr_r[b] <= ptr_r[b];
        end
      end
    end
  end

  assign start_s = ptr_r;
`endif

  // Bank command registers; payload holds when the bank is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_cs    <= '0;
      bank_we    <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      cmd_idx_r  <= '0;
    end else begin
      bank_cs <= win_vld_s;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (win_vld_s[b]) begin
          bank_we[b]    <= client_we[win_idx_s[b]];
          bank_addr[b]  <= client_addr[win_idx_s[b]];
          bank_wdata[b] <= client_wdata[win_idx_s[b]];
          cmd_idx_r[b]  <= win_idx_s[b];
        end else begin
          bank_we[b]    <= bank_we[b];
          bank_addr[b]  <= bank_addr[b];
          bank_wdata[b] <= bank_wdata[b];
          cmd_idx_r[b]  <= cmd_idx_r[b];
        end
      end
    end
  end

  // Owner pipeline aligned to the bank read latency; only reads set the valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r <= '0;
      pipe_idx_r <= '0;
    end else begin
      pipe_vld_r[0] <= bank_cs & ~bank_we;
      pipe_idx_r[0] <= cmd_idx_r;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_vld_r[s] <= pipe_vld_r[s-1];
        pipe_idx_r[s] <= pipe_idx_r[s-1];
      end
    end
  end

  assign bank_rd_vld    = pipe_vld_r[RD_LAT-1];
  assign client_to_send = pipe_idx_r[RD_LAT-1];

endmodule

// File: tb/tb_mem_req_arb.sv
// Self-checking bench for mem_req_arb: scenario tasks plus a read-return scoreboard.
module tb_mem_req_arb;
  localparam int NC = 32;
  localparam int NB = 16;
  localparam int AW = 10;
  localparam int DW = 256;
  localparam int RL = 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NC-1:0]           client_req;
  logic [NC-1:0]           client_we;
  logic [NC-1:0][3:0]      client_bank;
  logic [NC-1:0][AW-1:0]   client_addr;
  logic [NC-1:0][DW-1:0]   client_wdata;
  logic [NC-1:0]           client_gnt;
  logic [NB-1:0]           bank_cs;
  logic [NB-1:0]           bank_we;
  logic [NB-1:0][AW-1:0]   bank_addr;
  logic [NB-1:0][DW-1:0]   bank_wdata;
  logic [NB-1:0]           bank_rd_vld;
  logic [NB-1:0][4:0]      client_to_send;

  typedef struct {
    int due;
    int bank;
    int idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  mem_req_arb #(
    .NUM_CLIENTS(NC), .NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .client_req(client_req), .client_we(client_we), .client_bank(client_bank),
    .client_addr(client_addr), .client_wdata(client_wdata), .client_gnt(client_gnt),
    .bank_cs(bank_cs), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_rd_vld(bank_rd_vld), .client_to_send(client_to_send)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-return scoreboard: every bank, every cycle, against the expected owner
  always @(negedge clk) begin
    logic ev;
    int   ei;
    for (int b = 0; b < NB; b++) begin
      ev = 1'b0;
      ei = 0;
      for (int k = sb_q.size() - 1; k >= 0; k--) begin
        if (sb_q[k].due == cyc && sb_q[k].bank == b) begin
          ev = 1'b1;
          ei = sb_q[k].idx;
          sb_q.delete(k);
        end
      end
      if (ev || bank_rd_vld[b]) begin
        n_checks++;
        if (bank_rd_vld[b] !== ev || (ev && client_to_send[b] !== 5'(ei))) begin
          $display("FAIL rd_return bank %0d cyc %0d: got vld=%b idx=%0d, want vld=%b idx=%0d",
                   b, cyc, bank_rd_vld[b], client_to_send[b], ev, ei);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    client_req   = '0;
    client_we    = '0;
    client_bank  = '0;
    client_addr  = '0;
    client_wdata = '0;
  endtask

  task automatic drive(input int c, input logic we, input int b,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    client_req[c]   = 1'b1;
    client_we[c]    = we;
    client_bank[c]  = 4'(b);
    client_addr[c]  = a;
    client_wdata[c] = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    n_checks++;
    if ({bank_cs, bank_we, bank_rd_vld} !== 48'd0 || bank_addr !== '0 || client_to_send !== '0) begin
      $display("FAIL reset_outputs: got cs=%h we=%h vld=%h, want all 0", bank_cs, bank_we, bank_rd_vld);
    end else begin
      n_pass++;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_midstream();
    clear_inputs();
    for (int c = 0; c < 4; c++) drive(c, 1'b0, c, 10'(c + 16), '0);
    step();
    clear_inputs();
    n_checks++;
    if (bank_cs !== 16'h000F) begin
      $display("FAIL midreset_inflight: got cs=%h want %h", bank_cs, 16'h000F);
    end else begin
      n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bank_cs, bank_we, bank_rd_vld} !== 48'd0 || bank_addr !== '0 || bank_wdata !== '0 ||
        client_to_send !== '0 || client_gnt !== 32'd0) begin
      $display("FAIL midreset_outputs: got cs=%h we=%h vld=%h gnt=%h, want all 0",
               bank_cs, bank_we, bank_rd_vld, client_gnt);
    end else begin
      n_pass++;
    end
    step();
    step();
    rst_n = 1'b1;
    repeat (RL + 3) step();
  endtask

  task automatic test_single_read();
    int t;
    clear_inputs();
    drive(7, 1'b0, 3, 10'h012, '0);
    #1;
    t = cyc;
    n_checks++;
    if (client_gnt !== 32'h0000_0080) begin
      $display("FAIL single_gnt: got %h want %h", client_gnt, 32'h0000_0080);
    end else begin
      n_pass++;
    end
    sb_q.push_back('{due: t + 1 + RL, bank: 3, idx: 7});
    step();
    clear_inputs();
    n_checks++;
    if (bank_cs !== 16'h0008 || bank_we[3] !== 1'b0 || bank_addr[3] !== 10'h012) begin
      $display("FAIL single_cmd: got cs=%h we=%b addr=%h want cs=0008 we=0 addr=012",
               bank_cs, bank_we[3], bank_addr[3]);
    end else begin
      n_pass++;
    end
    repeat (RL + 2) step();
  endtask

  task automatic test_contention();
    int exp_seq[6];
`ifdef MEM_REQ_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 5, 31, 0, 5, 31};
`endif
    clear_inputs();
    drive(0, 1'b0, 9, 10'h001, '0);
    drive(5, 1'b0, 9, 10'h005, '0);
    drive(31, 1'b0, 9, 10'h01F, '0);
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (client_gnt !== (32'd1 << exp_seq[k])) begin
        $display("FAIL contention_gnt[%0d]: got %h want %h", k, client_gnt, 32'd1 << exp_seq[k]);
      end else begin
        n_pass++;
      end
      sb_q.push_back('{due: cyc + 1 + RL, bank: 9, idx: exp_seq[k]});
      step();
    end
    clear_inputs();
    repeat (RL + 2) step();
  endtask

  task automatic test_parallel();
    int t;
    clear_inputs();
    for (int c = 0; c < 16; c++) drive(c, 1'b0, c, 10'(c), '0);
    #1;
    t = cyc;
    n_checks++;
    if (client_gnt !== 32'h0000_FFFF) begin
      $display("FAIL parallel_gnt: got %h want %h", client_gnt, 32'h0000_FFFF);
    end else begin
      n_pass++;
    end
    for (int b = 0; b < 16; b++) sb_q.push_back('{due: t + 1 + RL, bank: b, idx: b});
    step();
    clear_inputs();
    n_checks++;
    if (bank_cs !== 16'hFFFF || bank_we !== 16'h0000) begin
      $display("FAIL parallel_cs: got cs=%h we=%h want cs=ffff we=0000", bank_cs, bank_we);
    end else begin
      n_pass++;
    end
    for (int b = 0; b < 16; b++) begin
      n_checks++;
      if (bank_addr[b] !== 10'(b)) begin
        $display("FAIL parallel_addr[%0d]: got %h want %h", b, bank_addr[b], 10'(b));
      end else begin
        n_pass++;
      end
    end
    repeat (RL + 2) step();
  endtask

  task automatic test_write();
    logic [DW-1:0] ones;
    ones = {DW{1'b1}};
    clear_inputs();
    drive(20, 1'b1, 15, 10'h3FF, ones);
    #1;
    n_checks++;
    if (client_gnt !== 32'h0010_0000) begin
      $display("FAIL write_gnt: got %h want %h", client_gnt, 32'h0010_0000);
    end else begin
      n_pass++;
    end
    step();
    clear_inputs();
    n_checks++;
    if (bank_cs !== 16'h8000 || bank_we[15] !== 1'b1 || bank_addr[15] !== 10'h3FF ||
        bank_wdata[15] !== ones) begin
      $display("FAIL write_cmd: got cs=%h we=%b addr=%h wdata=%h want cs=8000 we=1 addr=3ff wdata=all-ones",
               bank_cs, bank_we[15], bank_addr[15], bank_wdata[15]);
    end else begin
      n_pass++;
    end
    repeat (RL + 2) step();
  endtask

  task automatic test_wrap();
    clear_inputs();
    drive(31, 1'b0, 2, 10'h031, '0);
    #1;
    n_checks++;
    if (client_gnt !== 32'h8000_0000) begin
      $display("FAIL wrap_gnt31: got %h want %h", client_gnt, 32'h8000_0000);
    end else begin
      n_pass++;
    end
    sb_q.push_back('{due: cyc + 1 + RL, bank: 2, idx: 31});
    step();
    clear_inputs();
    drive(0, 1'b0, 2, 10'h000, '0);
    drive(30, 1'b0, 2, 10'h030, '0);
    #1;
    n_checks++;
    if (client_gnt !== 32'h0000_0001) begin
      $display("FAIL wrap_gnt0: got %h want %h", client_gnt, 32'h0000_0001);
    end else begin
      n_pass++;
    end
    sb_q.push_back('{due: cyc + 1 + RL, bank: 2, idx: 0});
    step();
    client_req[0] = 1'b0;
    #1;
    n_checks++;
    if (client_gnt !== 32'h4000_0000) begin
      $display("FAIL wrap_gnt30: got %h want %h", client_gnt, 32'h4000_0000);
    end else begin
      n_pass++;
    end
    sb_q.push_back('{due: cyc + 1 + RL, bank: 2, idx: 30});
    step();
    clear_inputs();
    repeat (RL + 2) step();
  endtask

  task automatic test_same_bank_rw();
    clear_inputs();
    drive(1, 1'b1, 5, 10'h101, {DW{1'b0}});
    drive(2, 1'b0, 5, 10'h102, '0);
    #1;
    n_checks++;
    if (client_gnt !== 32'h0000_0002) begin
      $display("FAIL rw_first_gnt: got %h want %h", client_gnt, 32'h0000_0002);
    end else begin
      n_pass++;
    end
    step();
    client_req[1] = 1'b0;
    #1;
    n_checks++;
    if (client_gnt !== 32'h0000_0004 || bank_we[5] !== 1'b1 || bank_addr[5] !== 10'h101) begin
      $display("FAIL rw_second: got gnt=%h we=%b addr=%h want gnt=00000004 we=1 addr=101",
               client_gnt, bank_we[5], bank_addr[5]);
    end else begin
      n_pass++;
    end
    sb_q.push_back('{due: cyc + 1 + RL, bank: 5, idx: 2});
    step();
    clear_inputs();
    repeat (RL + 2) step();
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_single_read();
    test_contention();
    test_parallel();
    test_write();
    test_wrap();
    test_same_bank_rw();
    repeat (RL + 3) step();
    n_checks++;
    if (sb_q.size() != 0) begin
      $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
    end else begin
      n_pass++;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
